multi_timer: RTL and testbench

//  Parametrised multi-channel programmable timer for the 6502 system bus.

---
 rtl/multi_timer.sv | 162 ++++++++++++++++
 tb/tb_multi_timer.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/multi_timer.sv
// Multi-channel programmable timer for the 8-bit peripheral bus.
// Each channel has a prescaler, periodic/one-shot counting, a coherent count snapshot and a masked irq.
module multi_timer #(
  parameter int unsigned NCHAN = 2,
  parameter int unsigned WIDTH = 16,
  parameter int unsigned PSC_W = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [$clog2(NCHAN)+1:0] addr,
  input  logic [7:0]               dbw,
  input  logic                     we,
  input  logic                     re,
  output logic [7:0]               dbr,
  output logic                     irq
);

  localparam int unsigned AW = $clog2(NCHAN) + 2;

  logic [WIDTH-1:0] limit_q  [NCHAN];
  logic [WIDTH-1:0] limit_d  [NCHAN];
  logic [WIDTH-1:0] cnt_q    [NCHAN];
  logic [WIDTH-1:0] cnt_d    [NCHAN];
  logic [PSC_W-1:0] psc_q    [NCHAN];
  logic [PSC_W-1:0] psc_d    [NCHAN];
  logic [PSC_W-1:0] pcnt_q   [NCHAN];
  logic [PSC_W-1:0] pcnt_d   [NCHAN];
  logic [7:0]       shadow_q [NCHAN];
  logic [7:0]       shadow_d [NCHAN];
  logic [7:0]       snap_q   [NCHAN];
  logic [7:0]       snap_d   [NCHAN];
  logic [NCHAN-1:0] en_q, en_d;
  logic [NCHAN-1:0] oneshot_q, oneshot_d;
  logic [NCHAN-1:0] ie_q, ie_d;
  logic [NCHAN-1:0] shot_q, shot_d;
  logic             irq_q;

  logic [AW-1:0] ch_sel;
  logic [1:0]    off;
  logic          hit;
  logic [15:0]   lim16;
  logic [15:0]   cnt16;
  logic [15:0]   rd16;
  logic [7:0]    psc8;

  assign ch_sel = addr >> 2;
  assign off    = addr[1:0];
  assign irq    = irq_q;

  always_comb begin
    hit   = 1'b0;
    lim16 = '0;
    cnt16 = '0;
    en_d      = en_q;
    oneshot_d = oneshot_q;
    ie_d      = ie_q;
    shot_d    = shot_q;
    for (int c = 0; c < NCHAN; c++) begin
      limit_d[c]  = limit_q[c];
      cnt_d[c]    = cnt_q[c];
      psc_d[c]    = psc_q[c];
      pcnt_d[c]   = pcnt_q[c];
      shadow_d[c] = shadow_q[c];
      snap_d[c]   = snap_q[c];

      hit   = (ch_sel == AW'(c));
      lim16 = {dbw, shadow_q[c]};
      cnt16 = '0;
      cnt16[WIDTH-1:0] = cnt_q[c];

      if (we && hit) begin
        unique case (off)
          2'd0: shadow_d[c] = dbw;
          2'd1: limit_d[c] = lim16[WIDTH-1:0];
          2'd2: begin
            en_d[c]      = dbw[0];
            oneshot_d[c] = dbw[1];
            ie_d[c]      = dbw[2];
            if (dbw[7]) shot_d[c] = 1'b0;
            // Only a 0->1 enable restarts the count; 1->1 just updates mode bits
            if (dbw[0] && !en_q[c]) begin
              cnt_d[c]  = '0;
              pcnt_d[c] = '0;
            end
          end
          default: psc_d[c] = dbw[PSC_W-1:0];
        endcase
      end

      if (re && hit && (off == 2'd0)) snap_d[c] = cnt16[15:8];

      // Evaluated after the bus write so a hardware shot beats a same-cycle W1C
      if (en_q[c]) begin
        if (pcnt_q[c] == psc_q[c]) begin
          pcnt_d[c] = '0;
          if (cnt_q[c] >= limit_q[c]) begin
            cnt_d[c]  = '0;
            shot_d[c] = 1'b1;
            if (oneshot_q[c]) en_d[c] = 1'b0;
          end else begin
            cnt_d[c] = cnt_q[c] + 1'b1;
          end
        end else begin
          pcnt_d[c] = pcnt_q[c] + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int c = 0; c < NCHAN; c++) begin
        limit_q[c]  <= '1;
        cnt_q[c]    <= '0;
        psc_q[c]    <= '0;
        pcnt_q[c]   <= '0;
        shadow_q[c] <= '0;
        snap_q[c]   <= '0;
      end
      en_q      <= '0;
      oneshot_q <= '0;
      ie_q      <= '0;
      shot_q    <= '0;
      irq_q     <= 1'b0;
    end else begin
      for (int c = 0; c < NCHAN; c++) begin
        limit_q[c]  <= limit_d[c];
        cnt_q[c]    <= cnt_d[c];
        psc_q[c]    <= psc_d[c];
        pcnt_q[c]   <= pcnt_d[c];
        shadow_q[c] <= shadow_d[c];
        snap_q[c]   <= snap_d[c];
      end
      en_q      <= en_d;
      oneshot_q <= oneshot_d;
      ie_q      <= ie_d;
      shot_q    <= shot_d;
      irq_q     <= |(shot_q & ie_q);
    end
  end

  always_comb begin
    dbr  = '0;
    rd16 = '0;
    psc8 = '0;
    for (int c = 0; c < NCHAN; c++) begin
      if (ch_sel == AW'(c)) begin
        rd16 = '0;
        rd16[WIDTH-1:0] = cnt_q[c];
        psc8 = '0;
        psc8[PSC_W-1:0] = psc_q[c];
        unique case (off)
          2'd0:    dbr = rd16[7:0];
          2'd1:    dbr = snap_q[c];
          2'd2:    dbr = {shot_q[c], 4'b0000, ie_q[c], oneshot_q[c], en_q[c]};
          default: dbr = psc8;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_multi_timer.sv
// Directed bench for multi_timer: three channels so that one address range is unmapped.
module tb_multi_timer;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] addr = '0;
  logic [7:0] dbw = '0;
  logic       we = 1'b0;
  logic       re = 1'b0;
  logic [7:0] dbr;
  logic       irq;

  int n_run  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  multi_timer #(.NCHAN(3), .WIDTH(16), .PSC_W(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .addr  (addr),
    .dbw   (dbw),
    .we    (we),
    .re    (re),
    .dbr   (dbr),
    .irq   (irq)
  );

  // All tasks start and end just after a falling edge; a write lands on the next rising edge.
  task automatic wr(input logic [3:0] a, input logic [7:0] d);
    addr = a; dbw = d; we = 1'b1;
    @(negedge clk);
    we = 1'b0;
  endtask

  task automatic peek(input logic [3:0] a, output logic [7:0] v);
    addr = a;
    #1 v = dbr;
  endtask

  task automatic snap_rd(input logic [3:0] a, output logic [7:0] v);
    addr = a; re = 1'b1;
    #1 v = dbr;
    @(negedge clk);
    re = 1'b0;
  endtask

  task automatic test_reset();
    logic [7:0] v;
    wr(4'd3, 8'h02); wr(4'd0, 8'h03); wr(4'd1, 8'h00); wr(4'd2, 8'h05);
    repeat (20) @(negedge clk);
    peek(4'd2, v); n_run++;
    if (v !== 8'h85) begin n_fail++; $display("FAIL pre_reset_ctrl: got %h want %h", v, 8'h85); end
    n_run++;
    if (irq !== 1'b1) begin n_fail++; $display("FAIL pre_reset_irq: got %b want 1", irq); end
    #2 rst_n = 1'b0;
    #1; n_run++;
    if (irq !== 1'b0) begin n_fail++; $display("FAIL reset_irq: got %b want 0", irq); end
    for (int i = 0; i < 4; i++) begin
      peek(4'(i), v); n_run++;
      if (v !== 8'h00) begin n_fail++; $display("FAIL reset_reg%0d: got %h want 00", i, v); end
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    // LIMIT resets to all ones, so the count runs straight past 300
    wr(4'd2, 8'h01);
    repeat (300) @(negedge clk);
    snap_rd(4'd0, v); n_run++;
    if (v !== 8'h2C) begin n_fail++; $display("FAIL reset_limit_lo: got %h want 2c", v); end
    peek(4'd1, v); n_run++;
    if (v !== 8'h01) begin n_fail++; $display("FAIL reset_limit_hi: got %h want 01", v); end
    wr(4'd2, 8'h80);
  endtask

  task automatic test_periodic();
    logic [7:0] v;
    wr(4'd0, 8'hE7); wr(4'd1, 8'h03); wr(4'd3, 8'h00); wr(4'd2, 8'h01);
    repeat (999) @(negedge clk);
    peek(4'd2, v); n_run++;
    if (v !== 8'h01) begin n_fail++; $display("FAIL per_999: got %h want 01", v); end
    @(negedge clk);
    peek(4'd2, v); n_run++;
    if (v !== 8'h81) begin n_fail++; $display("FAIL per_1000: got %h want 81", v); end
    wr(4'd2, 8'h81);
    peek(4'd2, v); n_run++;
    if (v !== 8'h01) begin n_fail++; $display("FAIL per_w1c: got %h want 01", v); end
    repeat (998) @(negedge clk);
    peek(4'd2, v); n_run++;
    if (v !== 8'h01) begin n_fail++; $display("FAIL per_1999: got %h want 01", v); end
    @(negedge clk);
    peek(4'd2, v); n_run++;
    if (v !== 8'h81) begin n_fail++; $display("FAIL per_2000: got %h want 81", v); end
    wr(4'd2, 8'h80);
  endtask

  task automatic test_oneshot();
    logic [7:0] v;
    wr(4'd4, 8'h09); wr(4'd5, 8'h00); wr(4'd7, 8'h03); wr(4'd6, 8'h07);
    repeat (39) @(negedge clk);
    peek(4'd6, v); n_run++;
    if (v !== 8'h07) begin n_fail++; $display("FAIL os_39_ctrl: got %h want 07", v); end
    peek(4'd4, v); n_run++;
    if (v !== 8'h09) begin n_fail++; $display("FAIL os_39_cnt: got %h want 09", v); end
    @(negedge clk);
    peek(4'd6, v); n_run++;
    if (v !== 8'h86) begin n_fail++; $display("FAIL os_40_ctrl: got %h want 86", v); end
    n_run++;
    if (irq !== 1'b0) begin n_fail++; $display("FAIL os_40_irq: got %b want 0", irq); end
    @(negedge clk); n_run++;
    if (irq !== 1'b1) begin n_fail++; $display("FAIL os_41_irq: got %b want 1", irq); end
    repeat (10) @(negedge clk);
    peek(4'd4, v); n_run++;
    if (v !== 8'h00) begin n_fail++; $display("FAIL os_hold_cnt: got %h want 00", v); end
    peek(4'd6, v); n_run++;
    if (v !== 8'h86) begin n_fail++; $display("FAIL os_hold_ctrl: got %h want 86", v); end
    wr(4'd6, 8'h80);
    peek(4'd6, v); n_run++;
    if (v !== 8'h00) begin n_fail++; $display("FAIL os_clr_ctrl: got %h want 00", v); end
    n_run++;
    if (irq !== 1'b1) begin n_fail++; $display("FAIL os_clr_irq_lag: got %b want 1", irq); end
    @(negedge clk); n_run++;
    if (irq !== 1'b0) begin n_fail++; $display("FAIL os_clr_irq: got %b want 0", irq); end
  endtask

  task automatic test_coherent();
    logic [7:0] v;
    wr(4'd0, 8'hFF); wr(4'd1, 8'h01); wr(4'd2, 8'h01);
    repeat (255) @(negedge clk);
    snap_rd(4'd0, v); n_run++;
    if (v !== 8'hFF) begin n_fail++; $display("FAIL coh_lo: got %h want ff", v); end
    peek(4'd1, v); n_run++;
    if (v !== 8'h00) begin n_fail++; $display("FAIL coh_snap: got %h want 00", v); end
    snap_rd(4'd0, v); n_run++;
    if (v !== 8'h00) begin n_fail++; $display("FAIL coh_lo2: got %h want 00", v); end
    peek(4'd1, v); n_run++;
    if (v !== 8'h01) begin n_fail++; $display("FAIL coh_snap2: got %h want 01", v); end
    wr(4'd2, 8'h80);
  endtask

  task automatic test_boundaries();
    logic [7:0] v;
    // LIMIT=0, PSC=1: a shot on every tick, i.e. every second clock
    wr(4'd0, 8'h00); wr(4'd1, 8'h00); wr(4'd3, 8'h01); wr(4'd2, 8'h01);
    @(negedge clk);
    peek(4'd2, v); n_run++;
    if (v !== 8'h01) begin n_fail++; $display("FAIL l0_e1: got %h want 01", v); end
    @(negedge clk);
    peek(4'd2, v); n_run++;
    if (v !== 8'h81) begin n_fail++; $display("FAIL l0_e2: got %h want 81", v); end
    wr(4'd2, 8'h81);
    peek(4'd2, v); n_run++;
    if (v !== 8'h01) begin n_fail++; $display("FAIL l0_w1c: got %h want 01", v); end
    @(negedge clk);
    peek(4'd2, v); n_run++;
    if (v !== 8'h81) begin n_fail++; $display("FAIL l0_e4: got %h want 81", v); end
    @(negedge clk);
    wr(4'd2, 8'h81);
    peek(4'd2, v); n_run++;
    if (v !== 8'h81) begin n_fail++; $display("FAIL set_wins: got %h want 81", v); end
    wr(4'd2, 8'h80);
    wr(4'd3, 8'h00); wr(4'd0, 8'hFF); wr(4'd1, 8'h03); wr(4'd2, 8'h01);
    repeat (200) @(negedge clk);
    peek(4'd0, v); n_run++;
    if (v !== 8'hC8) begin n_fail++; $display("FAIL low_cnt200: got %h want c8", v); end
    wr(4'd0, 8'h05); wr(4'd1, 8'h00);
    peek(4'd2, v); n_run++;
    if (v !== 8'h01) begin n_fail++; $display("FAIL low_wr_ctrl: got %h want 01", v); end
    peek(4'd0, v); n_run++;
    if (v !== 8'hCA) begin n_fail++; $display("FAIL low_wr_cnt: got %h want ca", v); end
    @(negedge clk);
    peek(4'd2, v); n_run++;
    if (v !== 8'h81) begin n_fail++; $display("FAIL low_wrap_ctrl: got %h want 81", v); end
    peek(4'd0, v); n_run++;
    if (v !== 8'h00) begin n_fail++; $display("FAIL low_wrap_cnt: got %h want 00", v); end
    wr(4'd2, 8'h80);
  endtask

  task automatic test_isolation();
    logic [7:0] v;
    // ch0 period (4+1)*(1+1)=10, ch1 period (2+1)*(3+1)=12, ch1 enabled one clock later
    wr(4'd0, 8'h04); wr(4'd1, 8'h00); wr(4'd3, 8'h01);
    wr(4'd4, 8'h02); wr(4'd5, 8'h00); wr(4'd7, 8'h03);
    wr(4'd2, 8'h01); wr(4'd6, 8'h01);
    repeat (8) @(negedge clk);
    peek(4'd2, v); n_run++;
    if (v !== 8'h01) begin n_fail++; $display("FAIL iso_c0_9: got %h want 01", v); end
    @(negedge clk);
    peek(4'd2, v); n_run++;
    if (v !== 8'h81) begin n_fail++; $display("FAIL iso_c0_10: got %h want 81", v); end
    peek(4'd6, v); n_run++;
    if (v !== 8'h01) begin n_fail++; $display("FAIL iso_c1_10: got %h want 01", v); end
    repeat (2) @(negedge clk);
    peek(4'd6, v); n_run++;
    if (v !== 8'h01) begin n_fail++; $display("FAIL iso_c1_12: got %h want 01", v); end
    @(negedge clk);
    peek(4'd6, v); n_run++;
    if (v !== 8'h81) begin n_fail++; $display("FAIL iso_c1_13: got %h want 81", v); end
    wr(4'd2, 8'h81);
    peek(4'd2, v); n_run++;
    if (v !== 8'h01) begin n_fail++; $display("FAIL iso_c0_clr: got %h want 01", v); end
    repeat (5) @(negedge clk);
    peek(4'd2, v); n_run++;
    if (v !== 8'h01) begin n_fail++; $display("FAIL iso_c0_19: got %h want 01", v); end
    @(negedge clk);
    peek(4'd2, v); n_run++;
    if (v !== 8'h81) begin n_fail++; $display("FAIL iso_c0_20: got %h want 81", v); end
    peek(4'd6, v); n_run++;
    if (v !== 8'h81) begin n_fail++; $display("FAIL iso_c1_keep: got %h want 81", v); end
    wr(4'd14, 8'h07);
    for (int a = 12; a < 16; a++) begin
      peek(4'(a), v); n_run++;
      if (v !== 8'h00) begin n_fail++; $display("FAIL unmapped_%0d: got %h want 00", a, v); end
    end
    peek(4'd10, v); n_run++;
    if (v !== 8'h00) begin n_fail++; $display("FAIL iso_c2_ctrl: got %h want 00", v); end
    n_run++;
    if (irq !== 1'b0) begin n_fail++; $display("FAIL iso_irq: got %b want 0", irq); end
    wr(4'd2, 8'h80); wr(4'd6, 8'h80);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    test_reset();
    test_periodic();
    test_oneshot();
    test_coherent();
    test_boundaries();
    test_isolation();
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
